binary_up_counter: RTL and testbench

//  Synchronous, parameterised binary up counter. Companion to the team's ripple down counter.

---
 rtl/binary_up_counter_pkg.sv | 20 ++
 rtl/binary_up_counter_toggle_cell.sv | 33 +++
 rtl/binary_up_counter.sv | 125 ++++++++++++
 tb/tb_binary_up_counter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/binary_up_counter_pkg.sv
// rtl/binary_up_counter_pkg.sv - shared constants and helpers for the up counter
//
// Holds the default geometry and the SATURATE encodings. The down counter uses the same
// encodings.
package binary_up_counter_pkg;

    localparam int DEF_WIDTH     = 3;
    localparam int DEF_MOD_VALUE = 8;

    // SATURATE encodings
    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // True when the modulus fills the whole register. In that case, incrementing the
    // all-ones value overflows to zero without help.
    function automatic bit is_natural_wrap(input int width, input int mod_value);
        return mod_value == (1 << width);
    endfunction

endpackage

// File: rtl/binary_up_counter_toggle_cell.sv
// rtl/binary_up_counter_toggle_cell.sv - one-bit synchronous T flip-flop with load override
//
// Ports:
//   clk  in  rising-edge clock shared by every cell, so the bits have no ripple skew
//   rst  in  asynchronous active-high reset, which clears q
//   ld   in  synchronous load: q <= d. Takes priority over t
//   d    in  load value
//   t    in  toggle request
//   q    out registered bit
//   qbar out complement of q
module binary_up_counter_toggle_cell (
    input  logic clk,
    input  logic rst,
    input  logic ld,
    input  logic d,
    input  logic t,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/binary_up_counter.sv
// rtl/binary_up_counter.sv - synchronous modulo/saturating binary up counter
//
// Parameters:
//   WIDTH      counter width (>=1)
//   MOD_VALUE  modulus; the counter counts 0..MOD_VALUE-1 (2 <= MOD_VALUE <= 2**WIDTH)
//   SATURATE   CNT_WRAP: the counter wraps to 0. CNT_SAT: the counter holds at MOD_VALUE-1
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   en         in   count enable
//   clr        in   synchronous clear (highest priority)
//   load       in   synchronous load of load_val
//   load_val   in   value to load; values out of range are clamped to MOD_VALUE-1
//   q          out  registered count
//   tc         out  terminal count: q == MOD_VALUE-1
//   carry_out  out  cascade enable: en & tc & ~clr & ~load
//   wrap       out  one-cycle pulse after a wrap to 0
//   load_err   out  one-cycle pulse after an out-of-range load
module binary_up_counter
    import binary_up_counter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MOD_VALUE = DEF_MOD_VALUE,
    parameter int SATURATE  = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             carry_out,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] TERM         = WIDTH'(MOD_VALUE - 1);
    localparam logic [WIDTH:0]   MOD_EXT      = (WIDTH + 1)'(MOD_VALUE);
    localparam bit               NATURAL_WRAP = is_natural_wrap(WIDTH, MOD_VALUE);
    localparam bit               SAT_MODE     = (SATURATE == CNT_SAT);

    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] ld_val;
    logic             ld;
    logic             cnt_en;
    logic             wrap_nxt;
    logic             err_nxt;
    logic             in_range;
    logic             lower_ones;

    assign tc        = (q == TERM);
    assign carry_out = en & tc & ~clr & ~load;
    assign in_range  = ({1'b0, load_val} < MOD_EXT);

    // Priority mux: clr > load > en > hold. Clear, load and non-natural wrap all go
    // through the cells' ld/d inputs. Plain increments go through the toggle chain.
    always_comb begin
        ld       = 1'b0;
        ld_val   = '0;
        cnt_en   = 1'b0;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (clr) begin
            ld = 1'b1;
        end else if (load) begin
            ld = 1'b1;
            if (in_range) begin
                ld_val = load_val;
            end else begin
                ld_val  = TERM;
                err_nxt = 1'b1;
            end
        end else if (en) begin
            if (!tc) begin
                cnt_en = 1'b1;
            end else if (!SAT_MODE) begin
                wrap_nxt = 1'b1;
                // When the modulus fills the register, q is all ones here, so toggling
                // every bit gives 0. Otherwise the counter is forced back to 0 explicitly.
                if (NATURAL_WRAP) begin
                    cnt_en = 1'b1;
                end else begin
                    ld = 1'b1;
                end
            end
        end
    end

    // Synchronous carry chain: bit i toggles when every lower bit is 1.
    // This uses qbar, so a lower bit is 1 when its qbar is 0.
    always_comb begin
        lower_ones = 1'b1;
        tog        = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tog[i]     = cnt_en & lower_ones;
            lower_ones = lower_ones & ~qbar[i];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        binary_up_counter_toggle_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .ld   (ld),
            .d    (ld_val[i]),
            .t    (tog[i]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= wrap_nxt;
            load_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_binary_up_counter.sv
// tb/tb_binary_up_counter.sv - self-checking bench for binary_up_counter (four configurations)
module tb_binary_up_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = '0;

    logic [2:0] q0, q1, q2;
    logic [1:0] q3;
    wire  [3:0] tcv, cov, wrv, erv;

    int checks = 0;
    int failures = 0;

    // Model state per instance: 0 = M8 wrap, 1 = M6 wrap, 2 = M8 saturate, 3 = M2 (W=2) wrap
    int mq[4];
    int mwrap[4];
    int merr[4];

    always #5 clk = ~clk;

    binary_up_counter #(.WIDTH(3), .MOD_VALUE(8), .SATURATE(0)) u_m8 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .q(q0), .tc(tcv[0]), .carry_out(cov[0]), .wrap(wrv[0]), .load_err(erv[0]));
    binary_up_counter #(.WIDTH(3), .MOD_VALUE(6), .SATURATE(0)) u_m6 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .q(q1), .tc(tcv[1]), .carry_out(cov[1]), .wrap(wrv[1]), .load_err(erv[1]));
    binary_up_counter #(.WIDTH(3), .MOD_VALUE(8), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .q(q2), .tc(tcv[2]), .carry_out(cov[2]), .wrap(wrv[2]), .load_err(erv[2]));
    binary_up_counter #(.WIDTH(2), .MOD_VALUE(2), .SATURATE(0)) u_m2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val[1:0]),
        .q(q3), .tc(tcv[3]), .carry_out(cov[3]), .wrap(wrv[3]), .load_err(erv[3]));

    function automatic int mod_of(input int k);
        case (k)
            0: return 8;
            1: return 6;
            2: return 8;
            default: return 2;
        endcase
    endfunction

    function automatic int lv_of(input int k, input int lv);
        return (k == 3) ? (lv & 3) : lv;
    endfunction

    function automatic int q_of(input int k);
        case (k)
            0: return int'(q0);
            1: return int'(q1);
            2: return int'(q2);
            default: return int'(q3);
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mq[k] = 0; mwrap[k] = 0; merr[k] = 0;
        end
    endtask

    // The model applies the counter's rules directly to integers.
    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            int m;
            int lv;
            m = mod_of(k);
            lv = lv_of(k, int'(load_val));
            mwrap[k] = 0;
            merr[k] = 0;
            if (clr) begin
                mq[k] = 0;
            end else if (load) begin
                if (lv < m) begin
                    mq[k] = lv;
                end else begin
                    mq[k] = m - 1;
                    merr[k] = 1;
                end
            end else if (en) begin
                if (mq[k] < m - 1) mq[k] = mq[k] + 1;
                else if (k != 2) begin
                    mq[k] = 0;
                    mwrap[k] = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            int etc;
            etc = (mq[k] == mod_of(k) - 1) ? 1 : 0;
            chk("q", k, q_of(k), mq[k]);
            chk("tc", k, int'(tcv[k]), etc);
            chk("carry_out", k, int'(cov[k]), (en && etc && !clr && !load) ? 1 : 0);
            chk("wrap", k, int'(wrv[k]), mwrap[k]);
            chk("load_err", k, int'(erv[k]), merr[k]);
        end
    endtask

    task automatic step(input logic e, input logic c, input logic l, input logic [2:0] v);
        en = e; clr = c; load = l; load_val = v;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        // Hold reset for 3 clocks, then check the reset state.
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Free count: M8 wraps after 7, M6 after 5, M2 alternates, saturate holds at 7.
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 3'd0);

        // Load takes priority over en. Clear takes priority over load.
        step(1'b0, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b1, 3'd4);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b1, 3'd7);

        // Out-of-range load (7 for M6, 3 for M2), then wrap on the next en.
        step(1'b0, 1'b0, 1'b1, 3'd7);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b0, 1'b0, 3'd0);

        // Assert async reset between edges while counting.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        load = 1'b1;
        load_val = 3'd3;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 3'd0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step(r < 75, r >= 95, (r >= 60 && r < 72) || r == 99, 3'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
